// File: rtl/tlb_pkg.sv
// ----------------------------------------------------------------
// tlb_pkg : shared types and default widths for the TLB controller
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package tlb_pkg;
  localparam int TLB_VA_W     = 14;
  localparam int TLB_PA_W     = 10;
  localparam int TLB_OFFSET_W = 8;
  localparam int TLB_ROWS     = 4;
  localparam int TLB_CNT_W    = 16;
  localparam int TLB_VPN_W    = TLB_VA_W - TLB_OFFSET_W;
  localparam int TLB_PPN_W    = TLB_PA_W - TLB_OFFSET_W;
  localparam int TLB_AGE_W    = $clog2(TLB_ROWS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2,
    ST_RESP = 2'd3
  } tlb_state_t;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TLB_AGE_W-1:0] age;
    logic [TLB_VPN_W-1:0] tag;
    logic [TLB_PPN_W-1:0] ppn;
  } tlb_entry_t;
endpackage

`default_nettype wire

// File: rtl/tlb_lru.sv
// ----------------------------------------------------------------
// tlb_lru : true-LRU age registers, ages stay a permutation of 0..ROWS-1
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tlb_lru #(
  parameter int ROWS  = 4,
  parameter int AGE_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  touch,
  input  logic [AGE_W-1:0]      touch_idx,
  output logic [AGE_W-1:0]      lru_idx,
  output logic [ROWS*AGE_W-1:0] ages
);
  logic [AGE_W-1:0] r_age [ROWS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++) r_age[i] <= AGE_W'(i);
    end else if (clear) begin
      for (int i = 0; i < ROWS; i++) r_age[i] <= AGE_W'(i);
    end else if (touch) begin
      // younger entries than the touched one age by one; touched becomes MRU
      for (int i = 0; i < ROWS; i++) begin
        if (AGE_W'(i) == touch_idx)
          r_age[i] <= '0;
        else if (r_age[i] < r_age[touch_idx])
          r_age[i] <= r_age[i] + AGE_W'(1);
      end
    end
  end

  always_comb begin
    lru_idx = '0;
    for (int i = 0; i < ROWS; i++)
      if (r_age[i] == AGE_W'(ROWS - 1)) lru_idx = AGE_W'(i);
  end

  for (genvar g = 0; g < ROWS; g++) begin : g_ages
    assign ages[g*AGE_W +: AGE_W] = r_age[g];
  end
endmodule

`default_nettype wire

// File: rtl/tlb_ctrl.sv
// ----------------------------------------------------------------
// tlb_ctrl : clocked fully-associative TLB, page-table walk/writeback FSM
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

import tlb_pkg::*;

module tlb_ctrl #(
  parameter int VA_W     = TLB_VA_W,
  parameter int PA_W     = TLB_PA_W,
  parameter int OFFSET_W = TLB_OFFSET_W,
  parameter int ROWS     = TLB_ROWS,
  parameter int CNT_W    = TLB_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic                     req_write,
  input  logic [VA_W-1:0]          vaddr,
  output logic                     req_ready,
  output logic [PA_W-1:0]          paddr,
  output logic                     paddr_valid,
  output logic                     hit,
  output logic                     pt_req,
  output logic                     pt_we,
  output logic [VA_W-OFFSET_W-1:0] pt_vpn,
  output logic [PA_W-OFFSET_W-1:0] pt_ppn_out,
  input  logic [PA_W-OFFSET_W-1:0] pt_ppn_in,
  input  logic                     pt_done,
  input  logic                     flush,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic [CNT_W-1:0]         miss_cnt
);
  localparam int VPN_W = VA_W - OFFSET_W;
  localparam int PPN_W = PA_W - OFFSET_W;
  localparam int AGE_W = $clog2(ROWS);

  tlb_state_t       r_state, w_next;
  logic [ROWS-1:0]  r_valid, r_dirty;
  logic [VPN_W-1:0] r_tag [ROWS];
  logic [PPN_W-1:0] r_ppn [ROWS];
  logic [VA_W-1:0]  r_vaddr;
  logic             r_write;
  logic [AGE_W-1:0] r_victim;

  logic [VPN_W-1:0] w_vpn;
  logic [ROWS-1:0]  w_match;
  logic             w_hit, w_inv_found, w_accept, w_do_flush, w_install, w_touch;
  logic [AGE_W-1:0] w_hit_idx, w_inv_idx, w_victim, w_lru_idx, w_touch_idx;
  logic [ROWS*AGE_W-1:0] w_ages_unused;

  assign w_vpn     = vaddr[VA_W-1:OFFSET_W];
  assign req_ready = (r_state == ST_IDLE) && !flush;

  for (genvar g = 0; g < ROWS; g++) begin : g_cam
    assign w_match[g] = r_valid[g] && (r_tag[g] == w_vpn);
  end

  // descending scans so the lowest index wins on multiple candidates
  always_comb begin
    w_hit_idx   = '0;
    w_inv_found = 1'b0;
    w_inv_idx   = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (w_match[i]) w_hit_idx = AGE_W'(i);
      if (!r_valid[i]) begin
        w_inv_found = 1'b1;
        w_inv_idx   = AGE_W'(i);
      end
    end
  end

  assign w_hit    = |w_match;
  assign w_victim = w_inv_found ? w_inv_idx : w_lru_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_do_flush = 1'b0;
    w_install  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (flush) begin
          w_do_flush = 1'b1;
        end else if (req_valid) begin
          w_accept = 1'b1;
          if (!w_hit)
            w_next = (r_valid[w_victim] && r_dirty[w_victim]) ? ST_WB : ST_FILL;
        end
      end
      ST_WB:   if (pt_done) w_next = ST_FILL;
      ST_FILL: if (pt_done) begin
        w_next    = ST_RESP;
        w_install = 1'b1;
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_touch     = (w_accept && w_hit) || w_install;
  assign w_touch_idx = w_install ? r_victim : w_hit_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= '0;
      r_dirty     <= '0;
      for (int i = 0; i < ROWS; i++) begin
        r_tag[i] <= '0;
        r_ppn[i] <= '0;
      end
      r_vaddr     <= '0;
      r_write     <= 1'b0;
      r_victim    <= '0;
      paddr       <= '0;
      paddr_valid <= 1'b0;
      hit         <= 1'b0;
      pt_req      <= 1'b0;
      pt_we       <= 1'b0;
      pt_vpn      <= '0;
      pt_ppn_out  <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      paddr_valid <= 1'b0;
      hit         <= 1'b0;
      if (w_do_flush) begin
        r_valid <= '0;
        r_dirty <= '0;
      end
      if (w_accept) begin
        r_vaddr <= vaddr;
        r_write <= req_write;
        if (w_hit) begin
          paddr       <= {r_ppn[w_hit_idx], vaddr[OFFSET_W-1:0]};
          paddr_valid <= 1'b1;
          hit         <= 1'b1;
          if (req_write) r_dirty[w_hit_idx] <= 1'b1;
          if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
        end else begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
          r_victim <= w_victim;
          pt_req   <= 1'b1;
          if (r_valid[w_victim] && r_dirty[w_victim]) begin
            pt_we      <= 1'b1;
            pt_vpn     <= r_tag[w_victim];
            pt_ppn_out <= r_ppn[w_victim];
          end else begin
            pt_we  <= 1'b0;
            pt_vpn <= w_vpn;
          end
        end
      end
      if (r_state == ST_WB && pt_done) begin
        r_dirty[r_victim] <= 1'b0;
        pt_we             <= 1'b0;
        pt_vpn            <= r_vaddr[VA_W-1:OFFSET_W];
      end
      if (w_install) begin
        r_valid[r_victim] <= 1'b1;
        r_dirty[r_victim] <= r_write;
        r_tag[r_victim]   <= r_vaddr[VA_W-1:OFFSET_W];
        r_ppn[r_victim]   <= pt_ppn_in;
        pt_req            <= 1'b0;
        paddr             <= {pt_ppn_in, r_vaddr[OFFSET_W-1:0]};
        paddr_valid       <= 1'b1;
      end
    end
  end

  tlb_lru #(
    .ROWS  (ROWS),
    .AGE_W (AGE_W)
  ) u_lru (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (w_do_flush),
    .touch     (w_touch),
    .touch_idx (w_touch_idx),
    .lru_idx   (w_lru_idx),
    .ages      (w_ages_unused)
  );
endmodule

`default_nettype wire

// File: tb/tb_tlb_ctrl.sv
// ----------------------------------------------------------------
// tb_tlb_ctrl : self-checking bench for tlb_ctrl against an LRU-list model
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_tlb_ctrl;
  localparam int VA_W = 14, PA_W = 10, OFFSET_W = 8, ROWS = 4, CNT_W = 16;
  localparam int VPN_W = VA_W - OFFSET_W, PPN_W = PA_W - OFFSET_W;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             req_valid = 1'b0, req_write = 1'b0, flush = 1'b0, pt_done = 1'b0;
  logic [VA_W-1:0]  vaddr = '0;
  logic [PPN_W-1:0] pt_ppn_in = '0;
  logic             req_ready, paddr_valid, hit, pt_req, pt_we;
  logic [PA_W-1:0]  paddr;
  logic [VPN_W-1:0] pt_vpn;
  logic [PPN_W-1:0] pt_ppn_out;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  tlb_ctrl #(.VA_W(VA_W), .PA_W(PA_W), .OFFSET_W(OFFSET_W), .ROWS(ROWS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write), .vaddr(vaddr),
    .req_ready(req_ready), .paddr(paddr), .paddr_valid(paddr_valid), .hit(hit),
    .pt_req(pt_req), .pt_we(pt_we), .pt_vpn(pt_vpn), .pt_ppn_out(pt_ppn_out),
    .pt_ppn_in(pt_ppn_in), .pt_done(pt_done), .flush(flush),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // reference model: entry contents plus a recency list (front = most recent)
  bit m_valid [ROWS];
  bit m_dirty [ROWS];
  int m_tag   [ROWS];
  int m_ppn   [ROWS];
  int m_order [$];
  int m_hits, m_misses;
  int pt_mem  [64];

  function automatic void model_clear_entries();
    m_order = {};
    for (int i = 0; i < ROWS; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_order.push_back(i);
    end
  endfunction

  function automatic void model_touch(input int k);
    for (int i = 0; i < m_order.size(); i++)
      if (m_order[i] == k) begin
        m_order.delete(i);
        break;
      end
    m_order.push_front(k);
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 0; req_write = 0; flush = 0; pt_done = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_clear_entries();
    m_hits = 0;
    m_misses = 0;
  endtask

  // one request through whatever path the model predicts, checking each phase
  task automatic access(input int vpn, input int off, input bit wr, output bit obs_hit, output bit obs_wb);
    int k, v, d, exp_pa;
    bit ok;
    obs_hit = 0;
    obs_wb = 0;
    ok = 0;
    for (int t = 0; t < 10; t++) begin
      if (req_ready === 1'b1) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ready_wait: req_ready=%0b required 1", req_ready);
      return;
    end
    req_valid = 1; req_write = wr; vaddr = VA_W'((vpn << OFFSET_W) | off);
    @(posedge clk); #1;
    req_valid = 0; req_write = 0;
    k = -1;
    for (int i = 0; i < ROWS; i++)
      if (k < 0 && m_valid[i] && m_tag[i] == vpn) k = i;
    obs_hit = paddr_valid && hit;
    checks++;
    if ({paddr_valid, hit} !== {k >= 0, k >= 0}) begin
      errors++;
      $display("FAIL lookup vpn=%0h: valid/hit=%b%b required %b%b", vpn, paddr_valid, hit, k >= 0, k >= 0);
    end
    if (k >= 0) begin
      exp_pa = (m_ppn[k] << OFFSET_W) | off;
      checks++;
      if (paddr !== PA_W'(exp_pa)) begin
        errors++;
        $display("FAIL hit_paddr vpn=%0h: paddr=%0h required %0h", vpn, paddr, exp_pa);
      end
      m_hits++;
      if (wr) m_dirty[k] = 1;
      model_touch(k);
    end else begin
      m_misses++;
      v = -1;
      for (int i = 0; i < ROWS; i++) if (v < 0 && !m_valid[i]) v = i;
      if (v < 0) v = m_order[$];
      if (m_valid[v] && m_dirty[v]) begin
        obs_wb = pt_req && pt_we;
        d = $urandom_range(0, 3);
        repeat (d) begin @(posedge clk); #1; end
        checks++;
        if ({pt_req, pt_we, pt_vpn, pt_ppn_out} !== {1'b1, 1'b1, VPN_W'(m_tag[v]), PPN_W'(m_ppn[v])}) begin
          errors++;
          $display("FAIL writeback: req/we/vpn/ppn=%b/%b/%0h/%0h required 1/1/%0h/%0h",
                   pt_req, pt_we, pt_vpn, pt_ppn_out, m_tag[v], m_ppn[v]);
        end
        pt_done = 1; pt_ppn_in = PPN_W'($urandom);
        @(posedge clk); #1;
        pt_done = 0;
        m_dirty[v] = 0;
      end
      d = $urandom_range(0, 3);
      repeat (d) begin @(posedge clk); #1; end
      checks++;
      if ({pt_req, pt_we, pt_vpn} !== {1'b1, 1'b0, VPN_W'(vpn)}) begin
        errors++;
        $display("FAIL fill_req: req/we/vpn=%b/%b/%0h required 1/0/%0h", pt_req, pt_we, pt_vpn, vpn);
      end
      pt_done = 1; pt_ppn_in = PPN_W'(pt_mem[vpn]);
      @(posedge clk); #1;
      pt_done = 0;
      exp_pa = (pt_mem[vpn] << OFFSET_W) | off;
      checks++;
      if ({paddr_valid, hit, pt_req, paddr} !== {1'b1, 1'b0, 1'b0, PA_W'(exp_pa)}) begin
        errors++;
        $display("FAIL resp vpn=%0h: valid/hit/req/paddr=%b/%b/%b/%0h required 1/0/0/%0h",
                 vpn, paddr_valid, hit, pt_req, paddr, exp_pa);
      end
      m_valid[v] = 1; m_dirty[v] = wr; m_tag[v] = vpn; m_ppn[v] = pt_mem[vpn];
      model_touch(v);
      @(posedge clk); #1;
      checks++;
      if (paddr_valid !== 1'b0) begin
        errors++;
        $display("FAIL resp_pulse: paddr_valid=%b required 0", paddr_valid);
      end
    end
    checks++;
    if (hit_cnt !== CNT_W'(m_hits) || miss_cnt !== CNT_W'(m_misses)) begin
      errors++;
      $display("FAIL counters: hit/miss=%0d/%0d required %0d/%0d", hit_cnt, miss_cnt, m_hits, m_misses);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({paddr, paddr_valid, hit, pt_req, pt_we, pt_vpn, pt_ppn_out, hit_cnt, miss_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: paddr=%0h pv=%b hit=%b req=%b we=%b vpn=%0h ppn=%0h cnt=%0d/%0d required all 0",
               paddr, paddr_valid, hit, pt_req, pt_we, pt_vpn, pt_ppn_out, hit_cnt, miss_cnt);
    end
    apply_reset();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
    end
    pt_done = 1;
    @(posedge clk); #1;
    pt_done = 0;
    checks++;
    if (pt_req !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stray_done: pt_req=%b req_ready=%b required 0/1", pt_req, req_ready);
    end
  endtask

  task automatic test_cold_miss_and_hit();
    bit h, w;
    pt_mem[6'h0A] = 2;
    access(6'h0A, 8'h55, 0, h, w);
    checks++;
    if (h !== 1'b0 || paddr !== 10'h255 || miss_cnt !== 16'd1) begin
      errors++;
      $display("FAIL cold_miss: hit=%b paddr=%0h miss_cnt=%0d required 0/255/1", h, paddr, miss_cnt);
    end
    access(6'h0A, 8'h12, 0, h, w);
    checks++;
    if (h !== 1'b1 || paddr !== 10'h212 || hit_cnt !== 16'd1 || pt_req !== 1'b0) begin
      errors++;
      $display("FAIL hit_after_fill: hit=%b paddr=%0h hit_cnt=%0d pt_req=%b required 1/212/1/0",
               h, paddr, hit_cnt, pt_req);
    end
  endtask

  task automatic test_back_to_back();
    int offs [3];
    offs[0] = 8'h00; offs[1] = 8'h7E; offs[2] = 8'hFF;
    req_valid = 1;
    pt_done = 1;
    for (int i = 0; i < 3; i++) begin
      vaddr = VA_W'((6'h0A << OFFSET_W) | offs[i]);
      @(posedge clk); #1;
      checks++;
      if (paddr_valid !== 1'b1 || hit !== 1'b1 || paddr !== PA_W'((2 << OFFSET_W) | offs[i])) begin
        errors++;
        $display("FAIL b2b_hit%0d: valid/hit/paddr=%b/%b/%0h required 1/1/%0h",
                 i, paddr_valid, hit, paddr, (2 << OFFSET_W) | offs[i]);
      end
      m_hits++;
    end
    req_valid = 0;
    pt_done = 0;
    checks++;
    if (hit_cnt !== CNT_W'(m_hits) || pt_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: hit_cnt=%0d pt_req=%b required %0d/0", hit_cnt, pt_req, m_hits);
    end
  endtask

  task automatic test_lru_and_dirty();
    bit h, w;
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      pt_mem[i] = i - 1;
      access(i, i, 0, h, w);
    end
    access(1, 3, 0, h, w);
    access(5, 4, 0, h, w);
    access(2, 5, 0, h, w);
    checks++;
    if (h !== 1'b0) begin
      errors++;
      $display("FAIL lru_evict: vpn2 hit=%b required 0", h);
    end
    access(1, 6, 0, h, w);
    checks++;
    if (h !== 1'b1) begin
      errors++;
      $display("FAIL lru_keep: vpn1 hit=%b required 1", h);
    end
    access(1, 7, 1, h, w);
    for (int i = 0; i < 4; i++) access(10 + i, i, 0, h, w);
    checks++;
    if (w !== 1'b1) begin
      errors++;
      $display("FAIL dirty_wb: writeback seen=%b required 1", w);
    end
  endtask

  task automatic test_random();
    bit h, w;
    for (int n = 0; n < 60; n++)
      access($urandom_range(0, 7), $urandom_range(0, 255), bit'($urandom_range(0, 1)), h, w);
  endtask

  task automatic test_reset_mid_walk();
    bit h, w;
    apply_reset();
    req_valid = 1; vaddr = VA_W'(6'h15 << OFFSET_W);
    @(posedge clk); #1;
    req_valid = 0;
    checks++;
    if (pt_req !== 1'b1 || pt_we !== 1'b0) begin
      errors++;
      $display("FAIL walk_start: pt_req/pt_we=%b/%b required 1/0", pt_req, pt_we);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (pt_req !== 1'b0 || miss_cnt !== '0) begin
      errors++;
      $display("FAIL async_reset: pt_req=%b miss_cnt=%0d required 0/0", pt_req, miss_cnt);
    end
    apply_reset();
    access(6'h15, 8'h21, 0, h, w);
    checks++;
    if (h !== 1'b0) begin
      errors++;
      $display("FAIL reread_after_reset: hit=%b required 0", h);
    end
  endtask

  task automatic test_flush();
    bit h, w;
    access(3, 1, 1, h, w);
    access(3, 2, 0, h, w);
    flush = 1; req_valid = 1; vaddr = VA_W'(3 << OFFSET_W);
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: req_ready=%b required 0", req_ready);
    end
    @(posedge clk); #1;
    flush = 0; req_valid = 0;
    checks++;
    if (paddr_valid !== 1'b0 || pt_req !== 1'b0 || hit_cnt !== CNT_W'(m_hits) || miss_cnt !== CNT_W'(m_misses)) begin
      errors++;
      $display("FAIL flush_accept: pv=%b req=%b cnt=%0d/%0d required 0/0/%0d/%0d",
               paddr_valid, pt_req, hit_cnt, miss_cnt, m_hits, m_misses);
    end
    model_clear_entries();
    access(3, 3, 0, h, w);
    checks++;
    if (h !== 1'b0) begin
      errors++;
      $display("FAIL after_flush: hit=%b required 0", h);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) pt_mem[i] = $urandom_range(0, 3);
    model_clear_entries();
    m_hits = 0;
    m_misses = 0;
    test_reset();
    test_cold_miss_and_hit();
    test_back_to_back();
    test_lru_and_dirty();
    test_random();
    test_reset_mid_walk();
    test_random();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
